dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_arbiter_starve_counter.sv | 31 +++
 rtl/dmem_arbiter.sv | 106 ++++++++++
 tb/tb_dmem_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
// The debug read port borrows the data-memory port from the CPU.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W       = 8;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned STARVE_LIMIT = 16;
    localparam int unsigned CNT_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_GRANT = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating wait-cycle counter. Its terminal flag forces a debug grant
// once the CPU has held the memory port for too long.
module starve_counter #(
    parameter int unsigned LIMIT = dmem_arb_pkg::STARVE_LIMIT,
    parameter int unsigned W     = dmem_arb_pkg::CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         terminal
);
    import dmem_arb_pkg::*;

    localparam logic [W-1:0] TERM = W'(LIMIT - 1);

    // Clear wins over enable; the count never moves past TERM.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != TERM)) begin
            count <= count + W'(1);
        end
    end

    assign terminal = (count == TERM);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the CPU and a debug reader.
// The CPU keeps priority; a waiting debug read is forced through after a bounded wait.
module dmem_arbiter #(
    parameter int unsigned ADDR_W       = dmem_arb_pkg::ADDR_W,
    parameter int unsigned DATA_W       = dmem_arb_pkg::DATA_W,
    parameter int unsigned STARVE_LIMIT = dmem_arb_pkg::STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    import dmem_arb_pkg::*;

    arb_state_t       state;
    logic [CNT_W-1:0] starve_cnt;
    logic             starve_term;
    logic             cnt_clear;
    logic             cnt_enable;
    logic             grant_c;

    // Counter only runs while a debug request is being held off by the CPU.
    assign cnt_clear  = (state != ST_WAIT);
    assign cnt_enable = (state == ST_WAIT) && dbg_req && cpu_req;

    starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .W     (CNT_W)
    ) u_starve_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .count    (starve_cnt),
        .terminal (starve_term)
    );

    // Arbitration FSM with registered ack and captured debug data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            dbg_ack   <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            dbg_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dbg_req) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!dbg_req) begin
                        state <= ST_IDLE;
                    end else if (!cpu_req || starve_term) begin
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    dbg_rdata <= mem_rdata;
                    dbg_ack   <= 1'b1;
                    state     <= ST_ACK;
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Reset forces the port back to the CPU even if the state register still says GRANT.
    assign grant_c = (state == ST_GRANT) && !reset;

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_req & cpu_we;
        cpu_stall = 1'b0;
        if (grant_c) begin
            mem_addr  = dbg_addr;
            mem_we    = 1'b0;
            cpu_stall = cpu_req;
        end
    end

    assign cpu_rdata = cpu_stall ? '0 : mem_rdata;

    logic unused_ok;
    assign unused_ok = ^starve_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a scoreboard holds expected debug acks and
// CPU stall cycles, and a negedge monitor checks them as the DUT presents them.
module tb_dmem_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned SL = 16;

    logic          clk;
    logic          reset;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req;
    logic [AW-1:0] dbg_addr;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    dmem_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .dbg_req   (dbg_req),
        .dbg_addr  (dbg_addr),
        .dbg_ack   (dbg_ack),
        .dbg_rdata (dbg_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write on the rising edge.
    logic [DW-1:0] mem [0:255];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } ack_t;

    ack_t ack_q[$];
    int   stall_q[$];
    int   tests = 0;
    int   fails = 0;
    int   wr_cnt = 0;
    int   wr_cyc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack and stall the DUT presents must match the scoreboard.
    always @(negedge clk) begin
        if (dbg_ack === 1'b1) begin
            if (ack_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack: dbg_ack=1 at cycle %0d, expected 0", cyc);
            end else begin
                ack_t e;
                e = ack_q.pop_front();
                chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                chk("ack_data", dbg_rdata, e.data);
            end
        end
        if (cpu_stall === 1'b1) begin
            if (stall_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_stall: cpu_stall=1 at cycle %0d, expected 0", cyc);
            end else begin
                int s;
                s = stall_q.pop_front();
                chk("stall_cycle", 32'(cyc), 32'(s));
            end
        end
        if (mem_we === 1'b1 && mem_addr == 8'h20) begin
            wr_cnt++;
            wr_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int t0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h04] = 32'hA5A50004;
        mem[8'h08] = 32'h5A5A0008;
        mem[8'h0C] = 32'hC0FFEE0C;
        mem[8'h30] = 32'h0BADF00D;

        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 8'h30;
        cpu_wdata = '0;
        dbg_req   = 1'b0;
        dbg_addr  = '0;

        // Reset state
        tick();
        @(negedge clk);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_ack", 32'(dbg_ack), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rdata", dbg_rdata, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h30);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0BADF00D);

        // Idle CPU: minimum latency read
        tick();
        dbg_req  = 1'b1;
        dbg_addr = 8'h10;
        t0 = cyc;
        ack_q.push_back('{cyc: t0 + 3, data: 32'hDEADBEEF});
        repeat (3) tick();
        dbg_req = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("idle_rdata_hold", dbg_rdata, 32'hDEADBEEF);

        // Starvation: CPU reads continuously, grant forced after the limit
        tick();
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 8'h30;
        dbg_req  = 1'b1;
        dbg_addr = 8'h0C;
        t0 = cyc;
        ack_q.push_back('{cyc: t0 + SL + 2, data: 32'hC0FFEE0C});
        stall_q.push_back(t0 + SL + 1);
        for (int i = 0; i < int'(SL) + 2; i++) begin
            @(negedge clk);
            if (i == 5) chk("starve_cpu_rdata", cpu_rdata, 32'h0BADF00D);
            if (i == int'(SL) + 1) begin
                chk("grant_cpu_rdata", cpu_rdata, 32'd0);
                chk("grant_mem_addr", 32'(mem_addr), 32'h0C);
            end
            tick();
        end
        dbg_req = 1'b0;
        cpu_req = 1'b0;
        tick();

        // Write collision in the GRANT cycle
        dbg_req  = 1'b1;
        dbg_addr = 8'h08;
        t0 = cyc;
        ack_q.push_back('{cyc: t0 + 3, data: 32'h5A5A0008});
        stall_q.push_back(t0 + 2);
        tick();
        tick();
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 8'h20;
        cpu_wdata = 32'h12345678;
        @(negedge clk);
        chk("coll_grant_we", 32'(mem_we), 32'd0);
        chk("coll_grant_addr", 32'(mem_addr), 32'h08);
        tick();
        dbg_req = 1'b0;
        @(negedge clk);
        chk("coll_retry_we", 32'(mem_we), 32'd1);
        tick();
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        repeat (2) tick();
        chk("coll_wr_count", 32'(wr_cnt), 32'd1);
        chk("coll_wr_cycle", 32'(wr_cyc), 32'(t0 + 3));
        chk("coll_mem_data", mem[8'h20], 32'h12345678);

        // Abort: request withdrawn in the second WAIT cycle
        cpu_req  = 1'b1;
        cpu_addr = 8'h30;
        dbg_req  = 1'b1;
        dbg_addr = 8'h10;
        tick();
        tick();
        dbg_req = 1'b0;
        tick();
        cpu_req = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("abort_rdata", dbg_rdata, 32'h5A5A0008);
        chk("abort_ack", 32'(dbg_ack), 32'd0);

        // Reset in the GRANT cycle
        dbg_req  = 1'b1;
        dbg_addr = 8'h10;
        tick();
        tick();
        reset    = 1'b1;
        dbg_req  = 1'b0;
        cpu_req  = 1'b1;
        cpu_addr = 8'h40;
        @(negedge clk);
        chk("rstg_stall", 32'(cpu_stall), 32'd0);
        chk("rstg_mem_addr", 32'(mem_addr), 32'h40);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rstg_rdata", dbg_rdata, 32'd0);
        chk("rstg_ack", 32'(dbg_ack), 32'd0);
        chk("rstg_stall_after", 32'(cpu_stall), 32'd0);
        chk("rstg_mem_addr_after", 32'(mem_addr), 32'h40);
        tick();
        cpu_req  = 1'b0;
        cpu_addr = 8'h30;
        tick();

        // Back-to-back requests with dbg_req held through ACK
        dbg_req  = 1'b1;
        dbg_addr = 8'h04;
        t0 = cyc;
        ack_q.push_back('{cyc: t0 + 3, data: 32'hA5A50004});
        ack_q.push_back('{cyc: t0 + 7, data: 32'h5A5A0008});
        repeat (4) tick();
        dbg_addr = 8'h08;
        repeat (3) tick();
        dbg_req = 1'b0;
        repeat (3) tick();

        chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);
        chk("stall_queue_drained", 32'(stall_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
